// File: rtl/ghr_pkg.sv
// ghr_pkg: shared types and defaults for the global-history repair controller.
//   repairState_t     controller FSM states
//   HIST_BITS_DEFAULT default history width (matches the 2-bit shift register)
//   hist_t            history value at the default width
package ghr_pkg;

  typedef enum logic {IDLE, REPAIR} repairState_t;

  localparam int HIST_BITS_DEFAULT = 2;
  localparam int HIST_W            = HIST_BITS_DEFAULT;

  typedef logic [HIST_W-1:0] hist_t;

endpackage

// File: rtl/ghr_repair_ctrl_fifo.sv
// checkpoint_fifo: synchronous FIFO holding pre-shift history checkpoints,
// one per in-flight branch.
//   clk, reset  clock, synchronous active-high reset
//   push, pop   write dataIn / drop the oldest entry (both allowed together)
//   flush       empties the FIFO; wins over push and pop
//   dataIn      value to store
//   dataOut     oldest entry, combinational from the read pointer
//   count       occupied entries, 0..DEPTH
//   full, empty occupancy flags
module checkpoint_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign dataOut = mem[rptr];

  // Pointers are power-of-2 wide and wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (doPush) wptr <= wptr + AW'(1);
      if (doPop)  rptr <= rptr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (!reset && !flush && doPush) mem[wptr] <= dataIn;
  end

endmodule

// File: rtl/ghr_repair_ctrl.sv
// ghr_repair_ctrl: drives the shift-only global-history register.
// Issues one speculative shift per accepted prediction, checkpoints the
// pre-shift history per in-flight branch, and on an in-order mispredict
// rebuilds the correct history with HIST_BITS serial shifts (LSB first).
//   clk, reset                  clock, synchronous active-high reset
//   predValid/predTaken         offered prediction and its direction
//   predReady                   prediction accepted when predValid && predReady
//   resolveValid/Taken/Mispredict  oldest branch resolution
//   shiftEnable, shiftIn        to the history register (bit enters at MSB)
//   histShadow                  mirror of the history register contents
//   inFlight                    unresolved branches held in the checkpoint FIFO
//   busy                        high while repairing
//   protocolErr                 sticky: resolve with nothing in flight or during repair
module ghr_repair_ctrl
  import ghr_pkg::*;
#(
  parameter int HIST_BITS = HIST_BITS_DEFAULT,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   predValid,
  input  logic                   predTaken,
  output logic                   predReady,
  input  logic                   resolveValid,
  input  logic                   resolveTaken,
  input  logic                   resolveMispredict,
  output logic                   shiftEnable,
  output logic                   shiftIn,
  output logic [HIST_BITS-1:0]   histShadow,
  output logic [$clog2(DEPTH):0] inFlight,
  output logic                   busy,
  output logic                   protocolErr
);

  localparam int KW = (HIST_BITS > 1) ? $clog2(HIST_BITS) : 1;

  repairState_t         state;
  logic [KW-1:0]        k;
  logic [HIST_BITS-1:0] target;
  logic [HIST_BITS-1:0] ckpt;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 accept;
  logic                 resolveOk;
  logic                 doPop;
  logic                 doFlush;
  logic                 badResolve;

  always_comb begin
    // Gating on reset keeps the register quiet during the reset cycle.
    predReady   = !reset && (state == IDLE) && !fifoFull &&
                  !(resolveValid && resolveMispredict);
    accept      = predValid && predReady;
    resolveOk   = !reset && (state == IDLE) && resolveValid && !fifoEmpty;
    doPop       = resolveOk && !resolveMispredict;
    doFlush     = resolveOk && resolveMispredict;
    badResolve  = resolveValid && ((state == REPAIR) || fifoEmpty);
    shiftEnable = 1'b0;
    shiftIn     = 1'b0;
    if (!reset) begin
      if (state == REPAIR) begin
        shiftEnable = 1'b1;
        shiftIn     = target[k];
      end else if (accept) begin
        shiftEnable = 1'b1;
        shiftIn     = predTaken;
      end
    end
  end

  assign busy = (state == REPAIR);

  checkpoint_fifo #(
    .WIDTH (HIST_BITS),
    .DEPTH (DEPTH)
  ) u_ckpt (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (doPop),
    .flush   (doFlush),
    .dataIn  (histShadow),
    .dataOut (ckpt),
    .count   (inFlight),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      target      <= '0;
      histShadow  <= '0;
      protocolErr <= 1'b0;
    end else begin
      if (badResolve) protocolErr <= 1'b1;
      case (state)
        IDLE: begin
          // Correct history = checkpoint shifted once by the real outcome.
          if (doFlush) begin
            target <= HIST_BITS'({resolveTaken, ckpt} >> 1);
            k      <= '0;
            state  <= REPAIR;
          end
          if (accept) histShadow <= HIST_BITS'({predTaken, histShadow} >> 1);
        end
        REPAIR: begin
          // Shifting T[0..HIST_BITS-1] in at the MSB leaves exactly T behind.
          histShadow <= HIST_BITS'({target[k], histShadow} >> 1);
          if (k == KW'(HIST_BITS - 1)) begin
            k     <= '0;
            state <= IDLE;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghr_repair_ctrl.sv
module tb_ghr_repair_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       predValid, predTaken, predReady;
  logic       resolveValid, resolveTaken, resolveMispredict;
  logic       shiftEnable, shiftIn;
  logic [1:0] histShadow;
  logic [2:0] inFlight;
  logic       busy, protocolErr;

  int nVec = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  ghr_repair_ctrl #(.HIST_BITS(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .predValid(predValid), .predTaken(predTaken), .predReady(predReady),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken),
    .resolveMispredict(resolveMispredict),
    .shiftEnable(shiftEnable), .shiftIn(shiftIn), .histShadow(histShadow),
    .inFlight(inFlight), .busy(busy), .protocolErr(protocolErr)
  );

  // Inputs for one cycle; pr/se/si checked before the edge, the rest after.
  typedef struct {
    string      name;
    bit         rst, pv, pt, rv, rt, rm;
    bit         pr, se, si;
    logic [1:0] hist;
    logic [2:0] inf;
    bit         bsy, err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, bit rst, bit pv, bit pt, bit rv, bit rt, bit rm,
                              bit pr, bit se, bit si, logic [1:0] h, logic [2:0] f,
                              bit b, bit e);
    vec_t v;
    v.name = n; v.rst = rst; v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.rm = rm;
    v.pr = pr; v.se = se; v.si = si; v.hist = h; v.inf = f; v.bsy = b; v.err = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bit bad;
    logic aPr, aSe, aSi;
    @(negedge clk);
    reset = v.rst; predValid = v.pv; predTaken = v.pt;
    resolveValid = v.rv; resolveTaken = v.rt; resolveMispredict = v.rm;
    #1;
    aPr = predReady; aSe = shiftEnable; aSi = shiftIn;
    @(posedge clk);
    #1;
    bad = (aPr !== v.pr) || (aSe !== v.se) || (v.se && (aSi !== v.si)) ||
          (histShadow !== v.hist) || (inFlight !== v.inf) ||
          (busy !== v.bsy) || (protocolErr !== v.err);
    nVec++;
    if (bad) begin
      nBad++;
      $display("FAIL %s: got pr=%b se=%b si=%b hist=%b inf=%0d busy=%b err=%b, want pr=%b se=%b si=%b hist=%b inf=%0d busy=%b err=%b",
               v.name, aPr, aSe, aSi, histShadow, inFlight, busy, protocolErr,
               v.pr, v.se, v.si, v.hist, v.inf, v.bsy, v.err);
    end
  endtask

  initial begin
    reset = 1'b1; predValid = 0; predTaken = 0;
    resolveValid = 0; resolveTaken = 0; resolveMispredict = 0;

    //              name          rst pv pt rv rt rm  pr se si  hist   inf busy err
    vq.push_back(mk("reset",       1, 0,0, 0,0,0,  0, 0,0, 2'b00, 0, 0,0));
    vq.push_back(mk("idle",        0, 0,0, 0,0,0,  1, 0,0, 2'b00, 0, 0,0));
    vq.push_back(mk("predT",       0, 1,1, 0,0,0,  1, 1,1, 2'b10, 1, 0,0));
    vq.push_back(mk("predN",       0, 1,0, 0,0,0,  1, 1,0, 2'b01, 2, 0,0));
    vq.push_back(mk("predT2",      0, 1,1, 0,0,0,  1, 1,1, 2'b10, 3, 0,0));
    vq.push_back(mk("fill4",       0, 1,0, 0,0,0,  1, 1,0, 2'b01, 4, 0,0));
    vq.push_back(mk("full_rej",    0, 1,1, 0,0,0,  0, 0,0, 2'b01, 4, 0,0));
    vq.push_back(mk("full_res",    0, 1,1, 1,0,0,  0, 0,0, 2'b01, 3, 0,0));
    vq.push_back(mk("pushpop",     0, 1,1, 1,0,0,  1, 1,1, 2'b10, 3, 0,0));
    vq.push_back(mk("misp_a",      0, 1,1, 1,0,1,  0, 0,0, 2'b10, 0, 1,0));
    vq.push_back(mk("rep_a0",      0, 1,1, 0,0,0,  0, 1,0, 2'b01, 0, 1,0));
    vq.push_back(mk("rep_a1",      0, 0,0, 0,0,0,  0, 1,0, 2'b00, 0, 0,0));
    vq.push_back(mk("b_predT",     0, 1,1, 0,0,0,  1, 1,1, 2'b10, 1, 0,0));
    vq.push_back(mk("b_predT2",    0, 1,1, 0,0,0,  1, 1,1, 2'b11, 2, 0,0));
    vq.push_back(mk("misp_b",      0, 0,0, 1,0,1,  0, 0,0, 2'b11, 0, 1,0));
    vq.push_back(mk("rep_b0",      0, 0,0, 0,0,0,  0, 1,0, 2'b01, 0, 1,0));
    vq.push_back(mk("rep_b1",      0, 0,0, 0,0,0,  0, 1,0, 2'b00, 0, 0,0));
    vq.push_back(mk("c_predT",     0, 1,1, 0,0,0,  1, 1,1, 2'b10, 1, 0,0));
    vq.push_back(mk("c_resok",     0, 0,0, 1,1,0,  1, 0,0, 2'b10, 0, 0,0));
    vq.push_back(mk("c_predN",     0, 1,0, 0,0,0,  1, 1,0, 2'b01, 1, 0,0));
    vq.push_back(mk("misp_c",      0, 0,0, 1,1,1,  0, 0,0, 2'b01, 0, 1,0));
    vq.push_back(mk("rep_c0",      0, 1,0, 0,0,0,  0, 1,1, 2'b10, 0, 1,0));
    vq.push_back(mk("rep_c1",      0, 1,0, 0,0,0,  0, 1,1, 2'b11, 0, 0,0));
    vq.push_back(mk("empty_res",   0, 0,0, 1,0,1,  0, 0,0, 2'b11, 0, 0,1));
    vq.push_back(mk("reset2",      1, 0,0, 0,0,0,  0, 0,0, 2'b00, 0, 0,0));
    vq.push_back(mk("d_predT",     0, 1,1, 0,0,0,  1, 1,1, 2'b10, 1, 0,0));
    vq.push_back(mk("misp_d",      0, 0,0, 1,0,1,  0, 0,0, 2'b10, 0, 1,0));
    vq.push_back(mk("rep_d0_res",  0, 0,0, 1,0,0,  0, 1,0, 2'b01, 0, 1,1));
    vq.push_back(mk("rep_d1",      0, 0,0, 0,0,0,  0, 1,0, 2'b00, 0, 0,1));
    vq.push_back(mk("idle_err",    0, 0,0, 0,0,0,  1, 0,0, 2'b00, 0, 0,1));
    // second part, after the sticky-error hold
    vq.push_back(mk("e_predT",     0, 1,1, 0,0,0,  1, 1,1, 2'b10, 1, 0,1));
    vq.push_back(mk("e_predT2",    0, 1,1, 0,0,0,  1, 1,1, 2'b11, 2, 0,1));
    vq.push_back(mk("misp_e",      0, 0,0, 1,1,1,  0, 0,0, 2'b11, 0, 1,1));
    vq.push_back(mk("rst_in_rep",  1, 0,0, 0,0,0,  0, 0,0, 2'b00, 0, 0,0));
    vq.push_back(mk("after_rst",   0, 0,0, 0,0,0,  1, 0,0, 2'b00, 0, 0,0));

    for (int i = 0; i < 30; i++) apply(vq[i]);

    // Sticky error must survive idle cycles, with no shifts issued.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 0; predValid = 0; resolveValid = 0; resolveMispredict = 0;
      #1;
      nVec++;
      if (protocolErr !== 1'b1 || shiftEnable !== 1'b0 || histShadow !== 2'b00) begin
        nBad++;
        $display("FAIL sticky_err[%0d]: got err=%b se=%b hist=%b, want err=1 se=0 hist=00",
                 i, protocolErr, shiftEnable, histShadow);
      end
    end

    for (int i = 30; i < vq.size(); i++) apply(vq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
